// File: rtl/sdc_pkg.sv
// rtl/sdc_pkg.sv - shared types and helpers for the SDC supervisor
package sdc_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        OPEN   = 3'd1,
        CLOSED = 3'd2,
        FAULT  = 3'd3
    } sdc_state_e;

    localparam int SYNC_STAGES = 2;

    // Bits needed for a saturating counter that must reach max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdc_wd_channel.sv
// rtl/sdc_wd_channel.sv - one watchdog liveness monitor: sync, edge detect, timeout, seen flag
module sdc_wd_channel
    import sdc_pkg::*;
#(
    parameter int WD_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic watchdog,
    input  logic clear_seen,
    output logic timeout,
    output logic seen
);

    localparam int CW = cnt_width(WD_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(WD_TIMEOUT);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    logic [CW-1:0]          cnt;
    logic                   toggled;

    assign toggled = sync[SYNC_STAGES-1] ^ sync_q;
    assign timeout = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            sync_q <= 1'b0;
            cnt    <= '0;
            seen   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], watchdog};
            sync_q <= sync[SYNC_STAGES-1];
            if (toggled) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // Clearing wins so a re-armed supervisor always waits for a fresh edge.
            if (clear_seen) begin
                seen <= 1'b0;
            end else if (toggled) begin
                seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdc_supervisor.sv
// rtl/sdc_supervisor.sv - shutdown-circuit relay supervisor with watchdogs, debounce and sense check
module sdc_supervisor
    import sdc_pkg::*;
#(
    parameter int N_WD          = 2,
    parameter int WD_TIMEOUT    = 1000,
    parameter int DEBOUNCE      = 16,
    parameter int SENSE_TIMEOUT = 50
) (
    input  logic            clk,
    input  logic            Power_on_Reset_n,
    input  logic            AS_driving_mode,
    input  logic            AS_close_SDC,
    input  logic            TS_Activation_Button_cockpit,
    input  logic            TS_Activation_Button_external,
    input  logic [N_WD-1:0] Watchdog,
    input  logic            Shutdown_circuit,
    input  logic            Fault_clear,
    output logic            To_SDC_relais,
    output logic            SDC_is_Ready,
    output logic            Fault,
    output logic [N_WD:0]   Fault_code,
    output logic [2:0]      State
);

    localparam int DW = cnt_width(DEBOUNCE);
    localparam int SW = cnt_width(SENSE_TIMEOUT);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);
    localparam logic [SW-1:0] SENSE_MAX = SW'(SENSE_TIMEOUT);

    sdc_state_e state, state_nxt;

    logic [N_WD-1:0] wd_timeout;
    logic [N_WD-1:0] wd_seen;
    logic            any_to;
    logic            clear_seen;

    // Index 0 = cockpit (manual), index 1 = external (autonomous).
    logic [1:0]             btn_raw;
    logic [SYNC_STAGES-1:0] btn_sync [2];
    logic [DW-1:0]          deb_cnt  [2];
    logic [1:0]             deb_lvl;
    logic [1:0]             deb_q;
    logic [1:0]             press;
    logic                   valid_press;

    logic [SYNC_STAGES-1:0] sense_sync;
    logic [SW-1:0]          sense_cnt;
    logic                   sense_to;

    logic mode_q;
    logic mode_change;
    logic ready;

    for (genvar i = 0; i < N_WD; i++) begin : g_wd
        sdc_wd_channel #(
            .WD_TIMEOUT(WD_TIMEOUT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (Power_on_Reset_n),
            .watchdog   (Watchdog[i]),
            .clear_seen (clear_seen),
            .timeout    (wd_timeout[i]),
            .seen       (wd_seen[i])
        );
    end

    assign any_to  = |wd_timeout;
    assign btn_raw = {TS_Activation_Button_external, TS_Activation_Button_cockpit};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            deb_lvl[b] = (deb_cnt[b] == DEB_MAX);
        end
    end

    assign press       = deb_lvl & ~deb_q;
    assign valid_press = AS_driving_mode ? press[1] : press[0];
    assign sense_to    = (sense_cnt == SENSE_MAX);
    assign mode_change = (AS_driving_mode != mode_q);
    assign ready       = (state == OPEN) && !any_to && (AS_driving_mode ? AS_close_SDC : 1'b1);

    always_ff @(posedge clk or negedge Power_on_Reset_n) begin
        if (!Power_on_Reset_n) begin
            for (int b = 0; b < 2; b++) begin
                btn_sync[b] <= '0;
                deb_cnt[b]  <= '0;
            end
            deb_q      <= '0;
            sense_sync <= '0;
            sense_cnt  <= '0;
            mode_q     <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                btn_sync[b] <= {btn_sync[b][SYNC_STAGES-2:0], btn_raw[b]};
                if (!btn_sync[b][SYNC_STAGES-1]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] != DEB_MAX) begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
            deb_q      <= deb_lvl;
            sense_sync <= {sense_sync[SYNC_STAGES-2:0], Shutdown_circuit};
            mode_q     <= AS_driving_mode;
            // Only an open loop while the relay is commanded closed counts.
            if (state != CLOSED || sense_sync[SYNC_STAGES-1]) begin
                sense_cnt <= '0;
            end else if (sense_cnt != SENSE_MAX) begin
                sense_cnt <= sense_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Power_on_Reset_n) begin
        if (!Power_on_Reset_n) begin
            state      <= INIT;
            Fault_code <= '0;
        end else begin
            state <= state_nxt;
            if (clear_seen) begin
                Fault_code <= '0;
            end else begin
                Fault_code <= Fault_code | {sense_to, wd_timeout};
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        clear_seen = 1'b0;
        unique case (state)
            INIT: begin
                if (any_to) begin
                    state_nxt = FAULT;
                end else if (&wd_seen) begin
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (any_to) begin
                    state_nxt = FAULT;
                end else if (ready && valid_press) begin
                    state_nxt = CLOSED;
                end
            end
            CLOSED: begin
                if (any_to || sense_to) begin
                    state_nxt = FAULT;
                end else if (mode_change || (AS_driving_mode && !AS_close_SDC)) begin
                    state_nxt = OPEN;
                end
            end
            FAULT: begin
                if (Fault_clear && !any_to) begin
                    state_nxt  = INIT;
                    clear_seen = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign To_SDC_relais = (state == CLOSED);
    assign SDC_is_Ready  = ready;
    assign Fault         = (state == FAULT);
    assign State         = state;

endmodule

// File: tb/tb_sdc_supervisor.sv
// tb/tb_sdc_supervisor.sv - self-checking bench for sdc_supervisor
module tb_sdc_supervisor;

    localparam int N_WD     = 2;
    localparam int WD_TO    = 20;
    localparam int DEB      = 4;
    localparam int SENSE_TO = 8;
    localparam int IGN_LAT  = 2 + DEB + 1;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_OPEN   = 3'd1;
    localparam logic [2:0] S_CLOSED = 3'd2;
    localparam logic [2:0] S_FAULT  = 3'd3;

    logic            clk = 1'b0;
    logic            Power_on_Reset_n;
    logic            AS_driving_mode;
    logic            AS_close_SDC;
    logic            TS_Activation_Button_cockpit;
    logic            TS_Activation_Button_external;
    logic [N_WD-1:0] Watchdog;
    logic            Shutdown_circuit;
    logic            Fault_clear;
    logic            To_SDC_relais;
    logic            SDC_is_Ready;
    logic            Fault;
    logic [N_WD:0]   Fault_code;
    logic [2:0]      State;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [N_WD-1:0] wd_en;
    int              wd_period [N_WD];
    int              wd_last   [N_WD];

    sdc_supervisor #(
        .N_WD(N_WD), .WD_TIMEOUT(WD_TO), .DEBOUNCE(DEB), .SENSE_TIMEOUT(SENSE_TO)
    ) dut (
        .clk                           (clk),
        .Power_on_Reset_n              (Power_on_Reset_n),
        .AS_driving_mode               (AS_driving_mode),
        .AS_close_SDC                  (AS_close_SDC),
        .TS_Activation_Button_cockpit  (TS_Activation_Button_cockpit),
        .TS_Activation_Button_external (TS_Activation_Button_external),
        .Watchdog                      (Watchdog),
        .Shutdown_circuit              (Shutdown_circuit),
        .Fault_clear                   (Fault_clear),
        .To_SDC_relais                 (To_SDC_relais),
        .SDC_is_Ready                  (SDC_is_Ready),
        .Fault                         (Fault),
        .Fault_code                    (Fault_code),
        .State                         (State)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each enabled watchdog toggles once per its period; a disabled one stalls.
    initial begin
        int cnt [N_WD];
        Watchdog = '0;
        for (int i = 0; i < N_WD; i++) begin
            cnt[i]     = 0;
            wd_last[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_WD; i++) begin
                if (!wd_en[i]) begin
                    cnt[i] = wd_period[i];
                end else if (cnt[i] >= wd_period[i]) begin
                    Watchdog[i] = ~Watchdog[i];
                    wd_last[i]  = cyc;
                    cnt[i]      = 1;
                end else begin
                    cnt[i]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick(1);
            if (State === want) ok = 1'b1;
        end
    endtask

    // Holds a button for `width` cycles; lat = cycles from rise to relay closure, -1 if none.
    task automatic press_measure(input bit ext, input int width, output int lat);
        lat = -1;
        if (ext) TS_Activation_Button_external = 1'b1;
        else     TS_Activation_Button_cockpit  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == width) begin
                TS_Activation_Button_external = 1'b0;
                TS_Activation_Button_cockpit  = 1'b0;
            end
            if (lat < 0 && To_SDC_relais === 1'b1) lat = k;
        end
    endtask

    task automatic reopen_manual();
        AS_driving_mode = 1'b1;
        tick(2);
        AS_driving_mode = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        Power_on_Reset_n = 1'b0;
        tick(3);
        checks++;
        if ({To_SDC_relais, SDC_is_Ready, Fault, Fault_code, State} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got relay=%b ready=%b fault=%b code=%b state=%0d want all 0",
                     To_SDC_relais, SDC_is_Ready, Fault, Fault_code, State);
        end
        Power_on_Reset_n = 1'b1;
        tick(1);
        checks++;
        if (State !== S_INIT) begin
            errors++;
            $display("FAIL post_reset_state: got %0d want %0d", State, S_INIT);
        end
    endtask

    task automatic test_init_to_open();
        bit ok;
        wait_state(S_OPEN, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_to_open: state %0d want %0d", State, S_OPEN);
        end
        checks++;
        if (SDC_is_Ready !== 1'b1 || To_SDC_relais !== 1'b0) begin
            errors++;
            $display("FAIL open_manual_outputs: ready=%b relay=%b want ready=1 relay=0",
                     SDC_is_Ready, To_SDC_relais);
        end
    endtask

    task automatic test_manual_ignition();
        int lat;
        press_measure(1'b0, 10, lat);
        checks++;
        if (lat !== IGN_LAT) begin
            errors++;
            $display("FAIL manual_latency: got %0d want %0d", lat, IGN_LAT);
        end
        reopen_manual();
        checks++;
        if (State !== S_OPEN || To_SDC_relais !== 1'b0) begin
            errors++;
            $display("FAIL mode_change_reopen: state=%0d relay=%b want state=%0d relay=0",
                     State, To_SDC_relais, S_OPEN);
        end
        press_measure(1'b0, 3, lat);
        checks++;
        if (lat !== -1) begin
            errors++;
            $display("FAIL short_pulse: closure at %0d want none", lat);
        end
        press_measure(1'b1, 10, lat);
        checks++;
        if (lat !== -1 || State !== S_OPEN) begin
            errors++;
            $display("FAIL external_in_manual: lat=%0d state=%0d want none/%0d", lat, State, S_OPEN);
        end
    endtask

    task automatic test_random_debounce();
        int w, lat, exp_lat;
        for (int t = 0; t < 8; t++) begin
            w       = int'($urandom_range(1, 8));
            exp_lat = (w >= DEB) ? IGN_LAT : -1;
            press_measure(1'b0, w, lat);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL random_debounce w=%0d: got %0d want %0d", w, lat, exp_lat);
            end
            if (lat > 0) reopen_manual();
        end
    endtask

    task automatic test_autonomous();
        int lat;
        AS_driving_mode = 1'b1;
        AS_close_SDC    = 1'b0;
        tick(2);
        checks++;
        if (SDC_is_Ready !== 1'b0) begin
            errors++;
            $display("FAIL auto_not_ready: got %b want 0", SDC_is_Ready);
        end
        press_measure(1'b1, 10, lat);
        checks++;
        if (lat !== -1 || State !== S_OPEN) begin
            errors++;
            $display("FAIL auto_press_not_permitted: lat=%0d state=%0d want none/%0d", lat, State, S_OPEN);
        end
        AS_close_SDC = 1'b1;
        tick(1);
        checks++;
        if (SDC_is_Ready !== 1'b1) begin
            errors++;
            $display("FAIL auto_ready: got %b want 1", SDC_is_Ready);
        end
        press_measure(1'b1, 10, lat);
        checks++;
        if (lat !== IGN_LAT || State !== S_CLOSED) begin
            errors++;
            $display("FAIL auto_close: lat=%0d state=%0d want %0d/%0d", lat, State, IGN_LAT, S_CLOSED);
        end
        AS_close_SDC = 1'b0;
        tick(2);
        checks++;
        if (State !== S_OPEN || To_SDC_relais !== 1'b0 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL auto_permission_drop: state=%0d relay=%b fault=%b want %0d/0/0",
                     State, To_SDC_relais, Fault, S_OPEN);
        end
        AS_driving_mode = 1'b0;
        tick(2);
    endtask

    task automatic test_wd_stall();
        int  lat, fc;
        bit  ok;
        press_measure(1'b0, 10, lat);
        wd_en[1] = 1'b0;
        fc = -1;
        for (int k = 0; k < 60 && fc < 0; k++) begin
            tick(1);
            if (Fault === 1'b1) fc = cyc;
        end
        checks++;
        if (fc < wd_last[1] + WD_TO || fc > wd_last[1] + WD_TO + 6) begin
            errors++;
            $display("FAIL wd_timeout_time: fault at cycle %0d want %0d..%0d",
                     fc, wd_last[1] + WD_TO, wd_last[1] + WD_TO + 6);
        end
        checks++;
        if (Fault_code !== 3'b010 || To_SDC_relais !== 1'b0 || State !== S_FAULT) begin
            errors++;
            $display("FAIL wd_fault_outputs: code=%b relay=%b state=%0d want 010/0/%0d",
                     Fault_code, To_SDC_relais, State, S_FAULT);
        end
        Fault_clear = 1'b1;
        tick(1);
        Fault_clear = 1'b0;
        tick(1);
        checks++;
        if (State !== S_FAULT || Fault !== 1'b1) begin
            errors++;
            $display("FAIL clear_while_stalled: state=%0d fault=%b want %0d/1", State, Fault, S_FAULT);
        end
        wd_en[1] = 1'b1;
        tick(6);
        Fault_clear = 1'b1;
        tick(1);
        Fault_clear = 1'b0;
        checks++;
        if (State !== S_INIT || Fault !== 1'b0 || Fault_code !== '0) begin
            errors++;
            $display("FAIL clear_honoured: state=%0d fault=%b code=%b want %0d/0/000",
                     State, Fault, Fault_code, S_INIT);
        end
        wait_state(S_OPEN, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reinit_to_open: state %0d want %0d", State, S_OPEN);
        end
    endtask

    task automatic test_sense();
        int lat;
        bit ok;
        press_measure(1'b0, 10, lat);
        Shutdown_circuit = 1'b0;
        tick(SENSE_TO - 3);
        Shutdown_circuit = 1'b1;
        tick(12);
        checks++;
        if (State !== S_CLOSED || To_SDC_relais !== 1'b1) begin
            errors++;
            $display("FAIL sense_glitch: state=%0d relay=%b want %0d/1", State, To_SDC_relais, S_CLOSED);
        end
        Shutdown_circuit = 1'b0;
        tick(SENSE_TO);
        Shutdown_circuit = 1'b1;
        wait_state(S_FAULT, 20, ok);
        checks++;
        if (!ok || Fault_code !== 3'b100 || To_SDC_relais !== 1'b0) begin
            errors++;
            $display("FAIL sense_timeout: state=%0d code=%b relay=%b want %0d/100/0",
                     State, Fault_code, To_SDC_relais, S_FAULT);
        end
        Fault_clear = 1'b1;
        tick(1);
        Fault_clear = 1'b0;
        wait_state(S_OPEN, 60, ok);
    endtask

    task automatic test_async_reset();
        int lat;
        press_measure(1'b0, 10, lat);
        checks++;
        if (To_SDC_relais !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_closed: relay=%b want 1", To_SDC_relais);
        end
        #3;
        Power_on_Reset_n = 1'b0;
        #1;
        checks++;
        if ({To_SDC_relais, SDC_is_Ready, Fault, Fault_code, State} !== '0) begin
            errors++;
            $display("FAIL async_reset: relay=%b ready=%b fault=%b code=%b state=%0d want all 0",
                     To_SDC_relais, SDC_is_Ready, Fault, Fault_code, State);
        end
        tick(2);
        Power_on_Reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        Power_on_Reset_n              = 1'b0;
        AS_driving_mode               = 1'b0;
        AS_close_SDC                  = 1'b0;
        TS_Activation_Button_cockpit  = 1'b0;
        TS_Activation_Button_external = 1'b0;
        Shutdown_circuit              = 1'b1;
        Fault_clear                   = 1'b0;
        wd_en                         = '1;
        for (int i = 0; i < N_WD; i++) wd_period[i] = int'($urandom_range(6, 12));

        test_reset();
        test_init_to_open();
        test_manual_ignition();
        test_random_debounce();
        test_autonomous();
        test_wd_stall();
        test_sense();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
